// File: rtl/pipe_skid_reg.sv
// Two-entry skid register stage: a main entry drives the outputs and a skid entry
// absorbs one beat of back-pressure, so in_ready never depends on out_ready.
//
//   state | meaning
//   ------+-------------------------------------------------
//   EMPTY | no beat held, out_valid low
//   ONE   | main entry holds a beat, skid entry free
//   TWO   | main and skid entries both hold beats, in_ready low
module pipe_skid_reg #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_halt,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_halt,
  output logic              halted,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_data;
  logic              main_halt;
  logic [DATA_W-1:0] skid_data;
  logic              skid_halt;
  logic              halt_pending;

  logic accept;
  logic xfer;
  logic stall_event;

  // in_ready is a pure function of registered state
  assign in_ready    = (state != TWO) && !halt_pending && !halted;
  assign out_valid   = (state != EMPTY);
  assign out_data    = main_data;
  assign out_halt    = main_halt;
  assign occupancy   = state;

  assign accept      = in_valid && in_ready;
  assign xfer        = out_valid && out_ready;
  assign stall_event = out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= EMPTY;
      main_data    <= '0;
      main_halt    <= 1'b0;
      skid_data    <= '0;
      skid_halt    <= 1'b0;
      halt_pending <= 1'b0;
      halted       <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      if (stall_event && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end

      // a transfer during flush is still taken downstream
      if (xfer && main_halt) begin
        halted <= 1'b1;
      end

      if (flush) begin
        state        <= EMPTY;
        main_data    <= '0;
        main_halt    <= 1'b0;
        skid_data    <= '0;
        skid_halt    <= 1'b0;
        halt_pending <= 1'b0;
      end else begin
        if (xfer && main_halt) begin
          halt_pending <= 1'b0;
        end else if (accept && in_halt) begin
          halt_pending <= 1'b1;
        end

        case (state)
          EMPTY: begin
            if (accept) begin
              main_data <= in_data;
              main_halt <= in_halt;
              state     <= ONE;
            end
          end
          ONE: begin
            if (accept && xfer) begin
              main_data <= in_data;
              main_halt <= in_halt;
            end else if (accept) begin
              skid_data <= in_data;
              skid_halt <= in_halt;
              state     <= TWO;
            end else if (xfer) begin
              state <= EMPTY;
            end
          end
          TWO: begin
            if (xfer) begin
              main_data <= skid_data;
              main_halt <= skid_halt;
              state     <= ONE;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: constant vector table, directed corner sequences and
// random traffic checked against a queue-based model of the stage.
module tb_pipe_skid_reg;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_halt;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_halt;
  logic              halted;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_skid_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_halt   (in_halt),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_halt  (out_halt),
    .halted    (halted),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: FIFO of held beats plus the sticky flags
  typedef struct {
    logic [DATA_W-1:0] d;
    logic              h;
  } beat_t;

  beat_t m_q[$];
  bit    m_halted;
  bit    m_hp;
  int    m_stall;

  function automatic bit m_in_ready();
    return (m_q.size() < 2) && !m_hp && !m_halted;
  endfunction

  function automatic void model_step();
    bit    acc;
    bit    xf;
    beat_t b;
    acc = in_valid && m_in_ready();
    xf  = (m_q.size() > 0) && out_ready;
    if (reset) begin
      m_q.delete();
      m_halted = 0;
      m_hp     = 0;
      m_stall  = 0;
      return;
    end
    if ((m_q.size() > 0) && !out_ready && (m_stall < STALL_MAX)) m_stall++;
    if (xf && m_q[0].h) begin
      m_halted = 1;
      m_hp     = 0;
    end
    if (flush) begin
      m_q.delete();
      m_hp = 0;
    end else begin
      if (xf) void'(m_q.pop_front());
      if (acc) begin
        b.d = in_data;
        b.h = in_halt;
        m_q.push_back(b);
        if (in_halt) m_hp = 1;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("m_out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    chk("m_occupancy", 64'(occupancy), 64'(m_q.size()));
    chk("m_in_ready", 64'(in_ready), 64'(m_in_ready()));
    chk("m_halted", 64'(halted), 64'(m_halted));
    chk("m_stall_cnt", 64'(stall_cnt), 64'(m_stall));
    if (m_q.size() != 0) begin
      chk("m_out_data", out_data, m_q[0].d);
      chk("m_out_halt", 64'(out_halt), 64'(m_q[0].h));
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic [DATA_W-1:0] d,
                      input logic h, input logic fl, input logic ordy);
    reset     = r;
    in_valid  = iv;
    in_data   = d;
    in_halt   = h;
    flush     = fl;
    out_ready = ordy;
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r, iv;
    logic [63:0] d;
    logic        h, fl, ordy;
    logic        ov;
    logic [1:0]  occ;
    logic        ir;
    logic [63:0] od;
    logic        od_chk;
    logic        hl;
    logic [3:0]  st;
  } vec_t;

  vec_t vecs[16];

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_halt = 1'b0;
    flush = 1'b0; out_ready = 1'b0;

    //           r  iv d      h  fl rdy  ov occ ir od     chk hl st
    vecs[0]  = '{1, 0, 64'h0,  0, 0, 0,  0, 0,  1, 64'h0,  1,  0, 0};
    vecs[1]  = '{0, 1, 64'hA,  0, 0, 0,  1, 1,  1, 64'hA,  1,  0, 0};
    vecs[2]  = '{0, 1, 64'hB,  0, 0, 0,  1, 2,  0, 64'hA,  1,  0, 1};
    vecs[3]  = '{0, 1, 64'hD,  0, 0, 0,  1, 2,  0, 64'hA,  1,  0, 2};
    vecs[4]  = '{0, 0, 64'h0,  0, 0, 0,  1, 2,  0, 64'hA,  1,  0, 3};
    vecs[5]  = '{0, 0, 64'h0,  0, 0, 1,  1, 1,  1, 64'hB,  1,  0, 3};
    vecs[6]  = '{0, 0, 64'h0,  0, 0, 1,  0, 0,  1, 64'h0,  0,  0, 3};
    vecs[7]  = '{0, 1, 64'h1,  0, 0, 1,  1, 1,  1, 64'h1,  1,  0, 3};
    vecs[8]  = '{0, 1, 64'h2,  0, 0, 1,  1, 1,  1, 64'h2,  1,  0, 3};
    vecs[9]  = '{0, 1, 64'h3,  0, 0, 1,  1, 1,  1, 64'h3,  1,  0, 3};
    vecs[10] = '{0, 1, 64'h10, 0, 0, 0,  1, 2,  0, 64'h3,  1,  0, 4};
    vecs[11] = '{0, 1, 64'hC,  0, 1, 0,  0, 0,  1, 64'h0,  1,  0, 5};
    vecs[12] = '{0, 0, 64'h0,  0, 0, 1,  0, 0,  1, 64'h0,  1,  0, 5};
    vecs[13] = '{0, 1, 64'h21, 0, 0, 0,  1, 1,  1, 64'h21, 1,  0, 5};
    vecs[14] = '{0, 1, 64'h22, 0, 0, 0,  1, 2,  0, 64'h21, 1,  0, 6};
    vecs[15] = '{1, 1, 64'h23, 0, 1, 1,  0, 0,  1, 64'h0,  1,  0, 0};

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].r, vecs[i].iv, vecs[i].d, vecs[i].h, vecs[i].fl, vecs[i].ordy);
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ov));
      chk($sformatf("v%0d_occupancy", i), 64'(occupancy), 64'(vecs[i].occ));
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].ir));
      if (vecs[i].od_chk) chk($sformatf("v%0d_out_data", i), out_data, vecs[i].od);
      chk($sformatf("v%0d_halted", i), 64'(halted), 64'(vecs[i].hl));
      chk($sformatf("v%0d_stall_cnt", i), 64'(stall_cnt), 64'(vecs[i].st));
      if (vecs[i].r || vecs[i].fl) chk($sformatf("v%0d_out_halt", i), 64'(out_halt), 64'd0);
      compare_model();
    end

    // streaming at full rate
    step(1, 0, '0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step(0, 1, 64'(k), 0, 0, 1);
      chk("stream_out_data", out_data, 64'(k));
      chk("stream_occupancy", 64'(occupancy), 64'd1);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      compare_model();
    end

    // halt beat locks the input until reset
    step(1, 0, '0, 0, 0, 0);
    step(0, 1, 64'h5, 1, 0, 0);
    chk("halt_in_ready_pending", 64'(in_ready), 64'd0);
    chk("halt_out_halt", 64'(out_halt), 64'd1);
    step(0, 0, '0, 0, 0, 1);
    chk("halt_halted_set", 64'(halted), 64'd1);
    for (int k = 0; k < 12; k++) begin
      step(0, 1, 64'(k + 100), 0, 0, 1);
      chk("halt_in_ready_locked", 64'(in_ready), 64'd0);
      chk("halt_occupancy", 64'(occupancy), 64'd0);
      compare_model();
    end
    step(1, 0, '0, 0, 0, 0);
    chk("halt_reset_halted", 64'(halted), 64'd0);
    chk("halt_reset_in_ready", 64'(in_ready), 64'd1);

    // flush coinciding with transfer of a halt beat
    step(0, 1, 64'h7, 1, 0, 0);
    step(0, 0, '0, 0, 1, 1);
    chk("flush_xfer_halted", 64'(halted), 64'd1);
    chk("flush_xfer_occupancy", 64'(occupancy), 64'd0);
    chk("flush_xfer_out_data", out_data, 64'd0);
    compare_model();

    // stall counter saturation
    step(1, 0, '0, 0, 0, 0);
    step(0, 1, 64'h9, 0, 0, 0);
    for (int k = 0; k < 20; k++) step(0, 0, '0, 0, 0, 0);
    chk("sat_stall_cnt", 64'(stall_cnt), 64'(STALL_MAX));
    chk("sat_out_data", out_data, 64'h9);
    compare_model();

    // random traffic
    step(1, 0, '0, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      step(($urandom % 100) == 0, ($urandom % 4) != 0, {$urandom, $urandom},
           ($urandom % 24) == 0, ($urandom % 20) == 0, ($urandom % 3) != 0);
      compare_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 64, payload width per beat (covers 9-bit PC plus 32-bit instruction plus control).
REQ-002 Parameter CNT_W, default 16, width of stall counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 in_halt  input  1  beat carries halt marker.
REQ-009 flush  input  1  discard all held beats (branch or hazard squash).
REQ-010 out_valid  output  1  downstream beat present.
REQ-011 out_ready  input  1  downstream accepts beat.
REQ-012 out_data  output  DATA_W  downstream payload.
REQ-013 out_halt  output  1  halt marker of presented beat.
REQ-014 halted  output  1  sticky: halt beat has left the stage.
REQ-015 occupancy  output  2  beats held, 0..2.
REQ-016 stall_cnt  output  CNT_W  saturating count of back-pressure cycles.

Function
REQ-017 Accept = in_valid && in_ready; transfer = out_valid && out_ready; both evaluated in the same cycle.
REQ-018 Storage: main entry (drives out_*) and one skid entry; states EMPTY, ONE, TWO; occupancy encodes state as 0, 1, 2.
REQ-019 in_ready = (state != TWO) && !halt_pending && !halted, combinational from registers only, with no path from out_ready.
REQ-020 out_valid = (state != EMPTY); out_data and out_halt always come from the main entry.
REQ-021 EMPTY: accept -> ONE, main <= input; otherwise remain.
REQ-022 ONE: accept and transfer -> ONE, main <= input; accept only -> TWO, skid <= input; transfer only -> EMPTY; neither -> hold.
REQ-023 TWO: transfer -> ONE, main <= skid; otherwise hold; no accept is possible.
REQ-024 Latency: an accepted beat is visible on out_* the cycle after acceptance when the stage was EMPTY, or ONE with a simultaneous transfer.
REQ-025 Beats leave in acceptance order; no beat is duplicated or lost absent flush.
REQ-026 halt_pending sets on acceptance of a beat with in_halt=1; it blocks further accepts.
REQ-027 halted sets on transfer of a beat with out_halt=1, and halt_pending clears in the same cycle; halted stays set until reset.
REQ-028 Flush takes priority over accept and transfer: next state is EMPTY, main and skid data are cleared to 0, a same-cycle input is discarded, and halt_pending clears; halted is unaffected.
REQ-029 A same-cycle transfer during flush is still considered taken by downstream; halted sets if that beat carried halt.
REQ-030 stall_cnt increments each cycle out_valid=1 and out_ready=0; it saturates at 2^CNT_W-1 and is unaffected by flush.
REQ-031 Payload bits are stored verbatim; no width conversion is performed.

Reset
REQ-032 reset has priority over every other input, including flush.
REQ-033 Reset values: state EMPTY, occupancy 0, out_valid 0, out_data 0, out_halt 0, halted 0, halt_pending 0, stall_cnt 0, in_ready 1 from the cycle after reset deasserts.
REQ-034 Reset mid-operation discards held beats without a transfer and clears halted.

Verification
REQ-035 Streaming: out_ready=1 and in_valid=1 every cycle with data 1,2,3... -> out_data equals the accept sequence delayed one cycle, occupancy stays 1, in_ready stays 1.
REQ-036 Back-pressure: accept 0xA then 0xB with out_ready=0 -> occupancy 2, in_ready=0, stall_cnt counts; raise out_ready -> 0xA then 0xB out on consecutive cycles.
REQ-037 Flush in TWO together with in_valid=1, data 0xC -> next cycle occupancy 0, out_valid 0, out_data 0; 0xC is never output.
REQ-038 Halt: accept 0x5 with in_halt=1 -> in_ready=0 next cycle; after transfer halted=1 and in_ready stays 0 for 10+ cycles; reset -> halted=0, in_ready=1.
REQ-039 Saturation: CNT_W=4, out_ready=0 held for 20 cycles with one beat held -> stall_cnt holds 15.
REQ-040 Reset asserted in TWO during a flush -> all outputs take their REQ-033 values the next cycle.
